// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped timer: register offsets, CTRL layout,
// MODE codes and FSM state encodings (also used by the bus bridge and bench).
package timer_dev_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CTRL_W = 4;

  localparam logic [SEL_W-1:0] REG_CTRL   = 2'd0;
  localparam logic [SEL_W-1:0] REG_PRESET = 2'd1;
  localparam logic [SEL_W-1:0] REG_COUNT  = 2'd2;
  localparam logic [SEL_W-1:0] REG_RSVD   = 2'd3;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Bit layout matches CTRL_IM_BIT / CTRL_MODE_LSB / CTRL_EN_BIT.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counting timer on the M-stage data bus; raises irq when the
// count expires, either one-shot or auto-reload.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  output logic [DATA_W-1:0] dout,
  output logic              hit,
  output logic              irq
);

  logic [SEL_W-1:0]  reg_sel;
  logic              wr_ctrl;
  logic              wr_preset;
  logic              cfg_wr;
  logic              unused_addr_lsbs;

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_flag_q, irq_flag_d;

  // Address decode; the fourth word of the window is not claimed.
  assign reg_sel          = addr[3:2];
  assign hit              = (addr[31:4] == BASE[31:4]) && (reg_sel != REG_RSVD);
  assign wr_ctrl          = we && hit && (reg_sel == REG_CTRL);
  assign wr_preset        = we && hit && (reg_sel == REG_PRESET);
  assign cfg_wr           = wr_ctrl || wr_preset;
  assign unused_addr_lsbs = ^addr[1:0];

  assign irq = irq_flag_q & ctrl_q.im;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration writes restart the sequence from IDLE.
  always_comb begin
    state_d = state_q;
    if (cfg_wr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
        ST_LOAD: state_d = ST_CNT;
        ST_CNT: begin
          if (!ctrl_q.en)               state_d = ST_IDLE;
          else if (count_q <= 32'd1)    state_d = ST_INT;
        end
        ST_INT:  state_d = (ctrl_q.mode == MODE_AUTO) ? ST_LOAD : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Register file and counter updates; a bus write overrides the FSM actions.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    if (wr_ctrl) begin
      ctrl_d     = ctrl_t'(din[CTRL_W-1:0]);
      irq_flag_d = 1'b0;
    end else if (wr_preset) begin
      preset_d   = din;
      irq_flag_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: count_d = preset_q;
        ST_CNT: begin
          if (ctrl_q.en) begin
            if (count_q > 32'd1) begin
              count_d = count_q - 32'd1;
            end else begin
              count_d    = '0;
              irq_flag_d = 1'b1;
            end
          end
        end
        ST_INT: begin
          if (ctrl_q.mode == MODE_AUTO) irq_flag_d = 1'b0;
          else                          ctrl_d.en  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    dout = '0;
    if (hit) begin
      case (reg_sel)
        REG_CTRL:   dout = DATA_W'(ctrl_q);
        REG_PRESET: dout = preset_q;
        REG_COUNT:  dout = count_q;
        default:    dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed and randomized checks of timer_dev against a timeline model that
// derives COUNT/irq/CTRL from the number of cycles since the last configuration write.
module tb_timer_dev;
  import timer_dev_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        hit;
  logic        irq;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model state: what was last written and when.
  int unsigned edge_n = 0;
  int unsigned m_t0   = 0;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_frozen;
  bit          m_run;

  timer_dev #(.BASE(BASE)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .din  (din),
    .we   (we),
    .dout (dout),
    .hit  (hit),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd12);
  endfunction

  // Cycles since COUNT was loaded from PRESET (negative while still starting up).
  function automatic longint m_elapsed();
    return longint'(edge_n) - longint'(m_t0) - 2;
  endfunction

  function automatic longint m_n();
    return (m_preset == 32'd0) ? 64'd1 : longint'(m_preset);
  endfunction

  function automatic bit m_auto();
    return m_ctrl[2:1] == MODE_AUTO;
  endfunction

  function automatic logic [31:0] m_count();
    longint j;
    longint n;
    j = m_elapsed();
    n = m_n();
    if (!m_run || j < 0) return m_frozen;
    if (m_auto()) j = j % (n + 2);
    return (j >= n) ? 32'd0 : 32'(longint'(m_preset) - j);
  endfunction

  function automatic bit m_flag();
    longint j;
    longint n;
    j = m_elapsed();
    n = m_n();
    if (!m_run || j < 0) return 1'b0;
    if (m_auto()) return (j % (n + 2)) == n;
    return j >= n;
  endfunction

  function automatic logic [3:0] m_ctrl_now();
    logic [3:0] c;
    c = m_ctrl;
    if (m_run && !m_auto() && m_elapsed() >= m_n() + 1) c[0] = 1'b0;
    return c;
  endfunction

  function automatic logic [31:0] m_dout(input logic [31:0] a);
    if (!m_hit(a))          return 32'd0;
    if (a == BASE)          return {28'd0, m_ctrl_now()};
    if (a == BASE + 32'd4)  return m_preset;
    return m_count();
  endfunction

  function automatic logic m_irq();
    logic [3:0] c;
    c = m_ctrl_now();
    return m_flag() & c[3];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] c;
    logic [3:0]  cn;
    c  = m_count();
    cn = m_ctrl_now();
    m_frozen = c;
    m_ctrl   = cn;
    m_t0     = edge_n + 1;
    if (a == BASE) m_ctrl = d[3:0];
    else           m_preset = d;
    m_run = m_ctrl[0];
  endtask

  task automatic model_reset();
    m_ctrl   = '0;
    m_preset = '0;
    m_frozen = '0;
    m_run    = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, got, exp);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    addr = a;
    din  = d;
    we   = w;
    rst  = r;
    if (r) model_reset();
    else if (w && (a == BASE || a == BASE + 32'd4)) model_write(a, d);
    @(posedge clk);
    edge_n++;
    #1;
    check("hit",  32'(hit),  32'(m_hit(a)));
    check("dout", dout,      m_dout(a));
    check("irq",  32'(irq),  32'(m_irq()));
  endtask

  initial begin
    int first;
    int found;
    int seen;
    int op;
    logic [31:0] hold;
    int pulses[$];

    rst  = 1'b1;
    we   = 1'b0;
    addr = BASE;
    din  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      addr = BASE + 32'(4 * i);
      #1;
      check("rst_dout", dout, 32'd0);
      check("rst_hit",  32'(hit), 32'd1);
      check("rst_irq",  32'(irq), 32'd0);
    end
    step(BASE, 0, 1'b0, 1'b0);

    // One-shot: PRESET=5, CTRL=EN|IM
    step(BASE + 4, 32'd5, 1'b1, 1'b0);
    step(BASE, 32'h9, 1'b1, 1'b0);
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      step(BASE + 8, 0, 1'b0, 1'b0);
      if (k == 2) check("os_count_first", dout, 32'd5);
      if (irq === 1'b1 && first < 0) first = k;
    end
    check("os_irq_edge", 32'(first), 32'd7);
    step(BASE, 0, 1'b0, 1'b0);
    check("os_ctrl_en_cleared", dout, 32'h8);
    check("os_irq_held", 32'(irq), 32'd1);
    step(BASE, 32'h0, 1'b1, 1'b0);
    check("os_irq_cleared", 32'(irq), 32'd0);

    // Auto-reload: PRESET=3, CTRL=EN|MODE_AUTO|IM
    step(BASE + 4, 32'd3, 1'b1, 1'b0);
    step(BASE, 32'hB, 1'b1, 1'b0);
    for (int k = 1; k <= 26; k++) begin
      step(BASE + 8, 0, 1'b0, 1'b0);
      if (irq === 1'b1) pulses.push_back(k);
    end
    check("ar_npulses_ge4", 32'(pulses.size() >= 4), 32'd1);
    if (pulses.size() > 0) check("ar_first", 32'(pulses[0]), 32'd5);
    for (int i = 1; i < pulses.size(); i++)
      check("ar_period", 32'(pulses[i] - pulses[i-1]), 32'd5);
    step(BASE, 32'h0, 1'b1, 1'b0);

    // Masked one-shot: irq never visible
    step(BASE + 4, 32'd5, 1'b1, 1'b0);
    step(BASE, 32'h1, 1'b1, 1'b0);
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      step(BASE + 8, 0, 1'b0, 1'b0);
      if (irq !== 1'b0) seen++;
    end
    check("mask_irq_low", 32'(seen), 32'd0);

    // Disable mid-count freezes COUNT
    step(BASE + 4, 32'd6, 1'b1, 1'b0);
    step(BASE, 32'h1, 1'b1, 1'b0);
    repeat (4) step(BASE + 8, 0, 1'b0, 1'b0);
    step(BASE, 32'h0, 1'b1, 1'b0);
    repeat (5) step(BASE + 8, 0, 1'b0, 1'b0);
    check("freeze_count", dout, 32'd4);

    // Decode
    step(BASE + 4, 32'd7, 1'b1, 1'b0);
    step(BASE + 8,  32'd123, 1'b1, 1'b0);
    step(BASE + 12, 32'd55,  1'b1, 1'b0);
    step(BASE + 16, 32'd77,  1'b1, 1'b0);
    check("dec_outside_hit", 32'(hit), 32'd0);
    step(BASE + 4, 0, 1'b0, 1'b0);
    check("dec_preset_kept", dout, 32'd7);
    step(BASE + 8, 0, 1'b0, 1'b0);
    check("dec_count_kept", dout, 32'd4);
    step(32'h0000_0100, 0, 1'b0, 1'b0);
    check("dec_outside_read", dout, 32'd0);

    // Collision: PRESET write while COUNT reads 1
    step(BASE + 4, 32'd4, 1'b1, 1'b0);
    step(BASE, 32'h9, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(BASE + 8, 0, 1'b0, 1'b0);
      if (dout == 32'd1) found = 1;
    end
    check("coll_reach_one", 32'(found), 32'd1);
    step(BASE + 4, 32'd2, 1'b1, 1'b0);
    check("coll_no_irq", 32'(irq), 32'd0);
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      step(BASE + 8, 0, 1'b0, 1'b0);
      if (irq === 1'b1 && first < 0) first = k;
    end
    check("coll_restart_irq", 32'(first), 32'd4);

    // Reset mid-count
    step(BASE + 4, 32'd5, 1'b1, 1'b0);
    step(BASE, 32'hB, 1'b1, 1'b0);
    repeat (3) step(BASE + 8, 0, 1'b0, 1'b0);
    step(BASE + 8, 0, 1'b0, 1'b1);
    check("rst_mid_count", dout, 32'd0);
    step(BASE, 0, 1'b0, 1'b0);
    check("rst_mid_ctrl", dout, 32'd0);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 39));
      if (op == 0)       step(BASE + 8, 0, 1'b0, 1'b1);
      else if (op < 5)   step(BASE, $urandom, 1'b1, 1'b0);
      else if (op < 9)   step(BASE + 4, $urandom_range(0, 6), 1'b1, 1'b0);
      else if (op < 11)  step(BASE + 32'(4 * $urandom_range(2, 4)), $urandom, 1'b1, 1'b0);
      else if (op < 13) begin
        hold = $urandom & 32'hFFFF_FFFC;
        step(hold, 0, 1'b0, 1'b0);
      end
      else               step(BASE + 32'(4 * $urandom_range(0, 4)), 0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
